// File: rtl/regfile_dump_reader.sv
// Read-side master for the register file: streams a contiguous (wrapping) address
// range over valid/ready and keeps an additive checksum of the accepted words.
module regfile_dump_reader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] rdAddr,
  input  logic [DATA_W-1:0] rdData,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    FIN   = 2'd3
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   cur_q;
  logic [ADDR_W-1:0]   last_q;
  logic [DATA_W-1:0]   out_data_q;
  logic [ADDR_W-1:0]   out_addr_q;
  logic                out_valid_q;
  logic                busy_q;
  logic                done_q;
  logic [DATA_W-1:0]   checksum_q;

  logic [ADDR_W-1:0]   cur_d;
  logic [DATA_W-1:0]   checksum_d;
  logic                handshake;

  // NOTE: every signal written in always_comb gets a default first, so no path
  // can leave it unassigned and infer a latch.
  always_comb begin
    cur_d      = cur_q + 1'b1;            // wraps modulo NREGS by width
    checksum_d = checksum_q + out_data_q; // carry out is discarded
    handshake  = 1'b0;
    if (state_q == HOLD) begin
      handshake = out_valid_q & out_ready;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // in this block samples the values from before the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cur_q       <= '0;
      last_q      <= '0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      checksum_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // abort in the same cycle as start suppresses the dump
          if (start && !abort) begin
            cur_q      <= first_addr;
            last_q     <= last_addr;
            checksum_q <= '0;
            busy_q     <= 1'b1;
            state_q    <= FETCH;
          end
        end

        FETCH: begin
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            out_data_q  <= rdData;
            out_addr_q  <= cur_q;
            out_valid_q <= 1'b1;
            state_q     <= HOLD;
          end
        end

        HOLD: begin
          // a word presented alongside abort is dropped, not summed
          if (abort) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end else if (handshake) begin
            checksum_q  <= checksum_d;
            out_valid_q <= 1'b0;
            if (cur_q == last_q) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= FIN;
            end else begin
              cur_q   <= cur_d;
              state_q <= FETCH;
            end
          end
        end

        FIN: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // The read address is the registered cursor, stable for the whole FETCH cycle
  // and parked on its last value in IDLE/FIN.
  assign rdAddr    = cur_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign checksum  = checksum_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Self-checking bench for regfile_dump_reader: directed table, hand-written corner
// sequences and randomized dumps against a queue/array reference model.
module tb_regfile_dump_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [4:0]  first_addr;
  logic [4:0]  last_addr;
  logic [4:0]  rdAddr;
  logic [31:0] rdData;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_addr;
  logic        busy;
  logic        done;
  logic [31:0] checksum;

  logic [31:0] mem [32];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Behavioural register file: combinational read port.
  assign rdData = mem[rdAddr];

  regfile_dump_reader #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .rdAddr     (rdAddr),
    .rdData     (rdData),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_addr   (out_addr),
    .busy       (busy),
    .done       (done),
    .checksum   (checksum)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 32; i++) mem[i] = i * 32'h0101_0101;
  endtask

  // Runs one dump from the current negedge; checks each accepted word against the
  // model sequence and the final count/checksum/done behaviour.
  task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input int ready_pct,
                          output int words, output int cycles, output bit got_done);
    int          n;
    logic [31:0] exp_sum;
    n       = ((int'(l) - int'(f) + 32) % 32) + 1;
    exp_sum = 32'h0;
    for (int k = 0; k < n; k++) exp_sum += mem[(int'(f) + k) % 32];
    words      = 0;
    got_done   = 1'b0;
    first_addr = f;
    last_addr  = l;
    start      = 1'b1;
    out_ready  = 1'b0;
    @(negedge clk);
    start  = 1'b0;
    cycles = 0;
    while (!got_done && cycles < 4000) begin
      if (done) begin
        got_done = 1'b1;
      end else begin
        out_ready = ($urandom_range(99) < ready_pct);
        if (out_valid && out_ready) begin
          check("word_addr", 32'(out_addr), 32'((int'(f) + words) % 32));
          check("word_data", out_data, mem[(int'(f) + words) % 32]);
          words++;
        end
        @(negedge clk);
        cycles++;
      end
    end
    out_ready = 1'b0;
    check("dump_done", 32'(got_done), 32'd1);
    check("word_count", 32'(words), 32'(n));
    check("checksum", checksum, exp_sum);
    check("busy_at_done", 32'(busy), 32'd0);
    @(negedge clk);
    check("done_one_pulse", 32'(done), 32'd0);
    check("busy_after", 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic [4:0]  f;
    logic [4:0]  l;
    int          words;
    logic [31:0] sum;
  } vec_t;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    int   words;
    int   cycles;
    bit   got_done;
    int   k;
    int   cyc;

    // Expected values for the ramp contents reg[i] = i*32'h01010101.
    vecs[0] = '{f: 5'd0,  l: 5'd31, words: 32, sum: 32'hF1F1_F1F0};
    vecs[1] = '{f: 5'd30, l: 5'd1,  words: 4,  sum: 32'h3E3E_3E3E};
    vecs[2] = '{f: 5'd5,  l: 5'd5,  words: 1,  sum: 32'h0505_0505};
    vecs[3] = '{f: 5'd31, l: 5'd0,  words: 2,  sum: 32'h1F1F_1F1F};
    vecs[4] = '{f: 5'd1,  l: 5'd0,  words: 32, sum: 32'hF1F1_F1F0};

    reset = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    first_addr = '0; last_addr = '0;
    load_ramp();
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_checksum", checksum, 32'd0);
    check("rst_rdaddr", 32'(rdAddr), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run_dump(vecs[i].f, vecs[i].l, 100, words, cycles, got_done);
      check("vec_words", 32'(words), 32'(vecs[i].words));
      check("vec_checksum", checksum, vecs[i].sum);
      check("vec_cycles", 32'(cycles), 32'(2 * vecs[i].words));
    end

    // start with abort in the same cycle: nothing happens
    first_addr = 5'd2; last_addr = 5'd3; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("start_abort_valid", 32'(out_valid), 32'd0);
    check("start_abort_busy2", 32'(busy), 32'd0);

    // Backpressure with a register-file rewrite during the stall.
    first_addr = 5'd5; last_addr = 5'd5; start = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    for (int i = 0; i < 10; i++) begin
      if (i == 3) mem[5] = 32'hDEAD_BEEF;
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_data", out_data, 32'h0505_0505);
      check("bp_rdaddr", 32'(rdAddr), 32'd5);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_done", 32'(done), 32'd1);
    check("bp_checksum", checksum, 32'h0505_0505);
    check("bp_valid_after", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("bp_done_pulse", 32'(done), 32'd0);
    load_ramp();

    // Abort while the word at address 4 is presented: words 0..3 count.
    first_addr = 5'd0; last_addr = 5'd31; start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(out_valid && out_addr == 5'd4) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("abort_reached", 32'(out_valid && out_addr == 5'd4), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; out_ready = 1'b0;
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_checksum", checksum, 32'h0606_0606);
    k = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) k++;
      @(negedge clk);
    end
    check("abort_no_done", 32'(k), 32'd0);
    check("abort_checksum_hold", checksum, 32'h0606_0606);

    // start while busy is ignored, then reset lands in HOLD.
    first_addr = 5'd0; last_addr = 5'd31; start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0; cyc = 0;
    while (!(out_valid && out_addr == 5'd6) && cyc < 200) begin
      if (cyc == 3) begin
        start = 1'b1; first_addr = 5'd10; last_addr = 5'd12;
      end else begin
        start = 1'b0;
      end
      if (out_valid) begin
        check("busy_start_seq", 32'(out_addr), 32'(k));
        k++;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; out_ready = 1'b0;
    check("busy_start_words", 32'(k), 32'd6);
    check("busy_start_sum", checksum, 32'h0F0F_0F0F);
    #2 reset = 1'b0;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_checksum", checksum, 32'd0);
    check("midrst_rdaddr", 32'(rdAddr), 32'd0);
    check("midrst_out_addr", 32'(out_addr), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_dump(5'd0, 5'd3, 100, words, cycles, got_done);
    check("post_rst_sum", checksum, 32'h0606_0606);

    // Randomized dumps over random contents and random backpressure.
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    for (int it = 0; it < 20; it++) begin
      logic [4:0] f;
      logic [4:0] l;
      int         pct;
      f   = 5'($urandom_range(31));
      l   = 5'($urandom_range(31));
      pct = (it % 4 == 0) ? 100 : int'($urandom_range(90, 25));
      run_dump(f, l, pct, words, cycles, got_done);
      if (pct == 100) check("rand_cycles", 32'(cycles), 32'(2 * words));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
